// File: rtl/edge_capture_multi.sv
// Multi-channel edge catcher: per-channel synchroniser, glitch filter and mode-qualified
// edge detection, reported as pulses, sticky pending flags, a maskable irq and saturating counters.
module edge_capture_multi #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3,
    parameter int CNT_W       = 8
) (
    input  logic                                            clk,
    input  logic                                            reset_n,
    input  logic [NUM_CH-1:0]                               async_in,
    input  logic [2*NUM_CH-1:0]                             mode,
    input  logic [NUM_CH-1:0]                               irq_en,
    input  logic [NUM_CH-1:0]                               pend_clr,
    input  logic [NUM_CH-1:0]                               cnt_clr,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]  cnt_sel,
    output logic [NUM_CH-1:0]                               level_out,
    output logic [NUM_CH-1:0]                               edge_pulse,
    output logic [NUM_CH-1:0]                               pending,
    output logic                                            irq,
    output logic [CNT_W-1:0]                                cnt_data
);

    localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_LEN - 1);
    localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    // Saturating increment: an all-ones counter holds its value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    logic [NUM_CH-1:0] sync_r [SYNC_STAGES];
    logic [FCNT_W-1:0] fcnt_r [NUM_CH];
    logic [CNT_W-1:0]  cnt_r  [NUM_CH];
    logic [NUM_CH-1:0] sync_s;
    logic [NUM_CH-1:0] filt_r;
    logic [NUM_CH-1:0] filt_d_r;
    logic [NUM_CH-1:0] qual_s;
    logic [NUM_CH-1:0] edge_pulse_r;
    logic [NUM_CH-1:0] pending_r;
    logic              irq_r;
    logic [CNT_W-1:0]  cnt_data_s;

    // Synchroniser shift chain for every channel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_r[k] <= '0;
            end
        end else begin
            sync_r[0] <= async_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
        end
    end

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Glitch filter: accept a new level only after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_r   <= '0;
            filt_d_r <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                fcnt_r[i] <= '0;
            end
        end else begin
            filt_d_r <= filt_r;
            for (int i = 0; i < NUM_CH; i++) begin
                if (sync_s[i] == filt_r[i]) begin
                    fcnt_r[i] <= '0;
                end else if (fcnt_r[i] == FCNT_LAST) begin
                    filt_r[i] <= sync_s[i];
                    fcnt_r[i] <= '0;
                end else begin
                    fcnt_r[i] <= fcnt_r[i] + FCNT_ONE;
                end
            end
        end
    end

    // Edge qualification; mode only gates edges of the filtered level, so a mode write alone is silent.
    always_comb begin
        qual_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            qual_s[i] = (filt_r[i] & ~filt_d_r[i] & mode[2*i]) |
                        (~filt_r[i] & filt_d_r[i] & mode[2*i+1]);
        end
    end

    // Event reporting: pulse, sticky pending (set beats clear), irq and saturating counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_pulse_r <= '0;
            pending_r    <= '0;
            irq_r        <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            edge_pulse_r <= qual_s;
            pending_r    <= qual_s | (pending_r & ~pend_clr);
            irq_r        <= |(pending_r & irq_en);
            for (int i = 0; i < NUM_CH; i++) begin
                if (qual_s[i]) begin
                    cnt_r[i] <= cnt_clr[i] ? CNT_ONE : sat_inc(cnt_r[i]);
                end else if (cnt_clr[i]) begin
                    cnt_r[i] <= '0;
                end
            end
        end
    end

    // Counter read mux; unmatched selects fall through to zero.
    always_comb begin
        cnt_data_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_data_s = (cnt_sel == SEL_W'(i)) ? cnt_r[i] : cnt_data_s;
        end
    end

    assign level_out  = filt_r;
    assign edge_pulse = edge_pulse_r;
    assign pending    = pending_r;
    assign irq        = irq_r;
    assign cnt_data   = cnt_data_s;

endmodule

// File: tb/tb_edge_capture_multi.sv
// Bench for edge_capture_multi: table-driven channel vectors plus hand sequences, checked
// every cycle against a scoreboard of expected level changes and edge pulses.
module tb_edge_capture_multi;

    localparam int NCH  = 5;
    localparam int SW   = 3;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk;
    logic            reset_n;
    logic [NCH-1:0]  async_in;
    logic [2*NCH-1:0] mode;
    logic [NCH-1:0]  irq_en;
    logic [NCH-1:0]  pend_clr;
    logic [NCH-1:0]  cnt_clr;
    logic [SW-1:0]   cnt_sel;
    logic [NCH-1:0]  level_out;
    logic [NCH-1:0]  edge_pulse;
    logic [NCH-1:0]  pending;
    logic            irq;
    logic [CW-1:0]   cnt_data;

    edge_capture_multi #(
        .NUM_CH(NCH), .SYNC_STAGES(2), .FILTER_LEN(3), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .async_in(async_in), .mode(mode),
        .irq_en(irq_en), .pend_clr(pend_clr), .cnt_clr(cnt_clr), .cnt_sel(cnt_sel),
        .level_out(level_out), .edge_pulse(edge_pulse), .pending(pending),
        .irq(irq), .cnt_data(cnt_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int       due;
        int       ch;
        bit       is_pulse;
        logic     lvl;
    } sb_t;

    typedef struct {
        int         ch;
        logic [1:0] md;
        int         len;
        logic       ien;
        logic       e_rise;
        logic       e_fall;
        logic       e_lvl;
    } vec_t;

    sb_t      sb[$];
    vec_t     vecs[8];
    int       cyc;
    int       n_cmp;
    int       n_err;
    int       c;
    logic [NCH-1:0] m_pend;
    logic [NCH-1:0] m_lvl;
    logic           m_irq;
    int             m_cnt[NCH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int exp_cnt_of(input logic [SW-1:0] s);
        if (int'(s) < NCH) return m_cnt[s];
        return 0;
    endfunction

    task automatic push(input int due, input int ch, input bit is_pulse, input logic lvl);
        sb_t e;
        e.due = due; e.ch = ch; e.is_pulse = is_pulse; e.lvl = lvl;
        sb.push_back(e);
    endtask

    task automatic clear_model();
        m_pend = '0; m_lvl = '0; m_irq = 1'b0;
        for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
        sb.delete();
    endtask

    task automatic tick_raw();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One clock: apply the expected effects of this edge to the model, then compare all outputs.
    task automatic tick();
        logic [NCH-1:0] pc, cc, ie, pulse;
        pc = pend_clr; cc = cnt_clr; ie = irq_en;
        @(posedge clk);
        #1;
        cyc++;
        pulse = '0;
        for (int k = sb.size() - 1; k >= 0; k--) begin
            if (sb[k].due == cyc) begin
                if (sb[k].is_pulse) pulse[sb[k].ch] = 1'b1;
                else m_lvl[sb[k].ch] = sb[k].lvl;
                sb.delete(k);
            end
        end
        m_irq  = |(m_pend & ie);
        m_pend = pulse | (m_pend & ~pc);
        for (int i = 0; i < NCH; i++) begin
            if (pulse[i]) m_cnt[i] = cc[i] ? 1 : ((m_cnt[i] == CMAX) ? CMAX : m_cnt[i] + 1);
            else if (cc[i]) m_cnt[i] = 0;
        end
        check("edge_pulse", edge_pulse, pulse);
        check("pending", pending, m_pend);
        check("irq", irq, m_irq);
        check("level_out", level_out, m_lvl);
        check("cnt_data", cnt_data, exp_cnt_of(cnt_sel));
    endtask

    task automatic check_zero(input string name);
        check({name, "_pulse"}, edge_pulse, 0);
        check({name, "_pend"}, pending, 0);
        check({name, "_irq"}, irq, 0);
        check({name, "_lvl"}, level_out, 0);
        check({name, "_cnt"}, cnt_data, 0);
    endtask

    task automatic set_mode(input int ch, input logic [1:0] m);
        mode[2*ch +: 2] = m;
    endtask

    task automatic apply_vec(input vec_t r);
        int cs;
        set_mode(r.ch, r.md);
        irq_en[r.ch] = r.ien;
        cnt_sel = 3'(r.ch);
        tick();
        async_in[r.ch] = 1'b1;
        cs = cyc;
        if (r.e_lvl)  push(cs + 5, r.ch, 1'b0, 1'b1);
        if (r.e_rise) push(cs + 6, r.ch, 1'b1, 1'b0);
        repeat (r.len) tick();
        async_in[r.ch] = 1'b0;
        cs = cyc;
        if (r.e_lvl)  push(cs + 5, r.ch, 1'b0, 1'b0);
        if (r.e_fall) push(cs + 6, r.ch, 1'b1, 1'b0);
        repeat (10) tick();
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0;
        reset_n = 1'b0; async_in = '0; mode = '0; irq_en = '0;
        pend_clr = '0; cnt_clr = '0; cnt_sel = '0;
        clear_model();
        //          ch  mode   len  ien   rise  fall  lvl
        vecs[0] = '{1, 2'b11, 2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1, 2'b11, 3, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{2, 2'b10, 5, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{2, 2'b00, 5, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{4, 2'b11, 1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{3, 2'b01, 4, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{4, 2'b11, 7, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{0, 2'b10, 3, 1'b1, 1'b0, 1'b1, 1'b1};

        repeat (3) tick_raw();
        check_zero("rst_init");
        #2 reset_n = 1'b1;
        tick();

        // ch0 rising, held high; irq masked then enabled
        set_mode(0, 2'b01);
        tick();
        async_in[0] = 1'b1;
        c = cyc;
        push(c + 5, 0, 1'b0, 1'b1);
        push(c + 6, 0, 1'b1, 1'b0);
        repeat (5) tick();
        check("ch0_before_latency", edge_pulse[0], 0);
        tick();
        check("ch0_pulse_6th_edge", edge_pulse[0], 1);
        check("ch0_cnt", cnt_data, 1);
        check("ch0_pend", pending[0], 1);
        repeat (2) tick();
        check("irq_masked", irq, 0);
        irq_en[0] = 1'b1;
        tick();
        check("irq_enabled", irq, 1);
        async_in[0] = 1'b0;
        c = cyc;
        push(c + 5, 0, 1'b0, 1'b0);
        repeat (8) tick();
        pend_clr = '1;
        tick();
        pend_clr = '0;
        check("pend_clr", pending, 0);
        tick();

        for (int v = 0; v < 8; v++) apply_vec(vecs[v]);

        // mode writes with stable levels (low on ch2, high on ch4) must stay silent
        set_mode(2, 2'b11); repeat (3) tick();
        set_mode(2, 2'b01); repeat (3) tick();
        set_mode(4, 2'b00); tick();
        async_in[4] = 1'b1;
        c = cyc;
        push(c + 5, 4, 1'b0, 1'b1);
        repeat (8) tick();
        set_mode(4, 2'b11); repeat (4) tick();
        set_mode(4, 2'b01); repeat (3) tick();
        set_mode(4, 2'b00); tick();
        async_in[4] = 1'b0;
        c = cyc;
        push(c + 5, 4, 1'b0, 1'b0);
        repeat (8) tick();

        // ch3 saturation over 20 toggles
        set_mode(3, 2'b11);
        cnt_sel = 3'd3;
        tick();
        for (int t = 0; t < 20; t++) begin
            async_in[3] = ~async_in[3];
            c = cyc;
            push(c + 5, 3, 1'b0, async_in[3]);
            push(c + 6, 3, 1'b1, 1'b0);
            repeat (3) tick();
        end
        repeat (8) tick();
        check("cnt_saturate", cnt_data, 15);

        // clears coinciding with an edge
        pend_clr = '1;
        tick();
        pend_clr = '0;
        async_in[3] = 1'b1;
        c = cyc;
        push(c + 5, 3, 1'b0, 1'b1);
        push(c + 6, 3, 1'b1, 1'b0);
        repeat (5) tick();
        cnt_clr[3] = 1'b1;
        pend_clr[3] = 1'b1;
        tick();
        cnt_clr = '0;
        pend_clr = '0;
        check("clr_edge_cnt", cnt_data, 1);
        check("clr_edge_pend", pending[3], 1);
        async_in[3] = 1'b0;
        c = cyc;
        push(c + 5, 3, 1'b0, 1'b0);
        push(c + 6, 3, 1'b1, 1'b0);
        repeat (10) tick();

        // all channels rise together, then counter read sweep
        mode = {NCH{2'b01}};
        irq_en = '1;
        tick();
        async_in = '1;
        c = cyc;
        for (int i = 0; i < NCH; i++) begin
            push(c + 5, i, 1'b0, 1'b1);
            push(c + 6, i, 1'b1, 1'b0);
        end
        repeat (6) tick();
        check("all_pulse", edge_pulse, 5'b11111);
        for (int s = 0; s < 8; s++) begin
            cnt_sel = 3'(s);
            tick();
            check("sel_sweep", cnt_data, exp_cnt_of(cnt_sel));
        end
        cnt_sel = 3'd6;
        tick();
        check("sel_out_of_range", cnt_data, 0);
        async_in = '0;
        c = cyc;
        for (int i = 0; i < NCH; i++) push(c + 5, i, 1'b0, 1'b0);
        repeat (8) tick();

        // reset during a filter count
        cnt_sel = 3'd0;
        async_in[1] = 1'b1;
        repeat (3) tick();
        #2 reset_n = 1'b0;
        #1 check_zero("rst_midfilt");
        async_in[1] = 1'b0;
        clear_model();
        repeat (2) tick_raw();
        #2 reset_n = 1'b1;
        repeat (8) tick();

        // reset while a pulse is high, input held high across release
        async_in[0] = 1'b1;
        c = cyc;
        push(c + 5, 0, 1'b0, 1'b1);
        push(c + 6, 0, 1'b1, 1'b0);
        repeat (6) tick();
        #2 reset_n = 1'b0;
        #1 check_zero("rst_midpulse");
        clear_model();
        repeat (2) tick_raw();
        #2 reset_n = 1'b1;
        c = cyc;
        push(c + 5, 0, 1'b0, 1'b1);
        push(c + 6, 0, 1'b1, 1'b0);
        repeat (9) tick();
        check("rise_after_reset", cnt_data, 1);

        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
